// File: rtl/cdm_error_sweep.sv
// rtl/cdm_error_sweep.sv - exhaustive operand sweep and error scoring around an approximate multiplier
//
// Drives every (A,B) operand pair into an external combinational multiplier,
// compares its product r_in with the exact product and accumulates error
// count, total error distance and the worst-case error with its operands.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   start     begin a sweep (ignored while busy)
//   r_in      approximate product for the current a_out/b_out
//   a_out     operand A (outer loop)
//   b_out     operand B (inner loop)
//   busy      sweep in progress
//   done      results valid, held until next accepted start or rst
//   err_count number of pairs with r_in != A*B
//   err_sum   sum of |A*B - r_in|
//   max_err   largest |A*B - r_in|
//   max_a     A of the first pair reaching max_err
//   max_b     B of the first pair reaching max_err
module cdm_error_sweep #(
  parameter int W    = 8,
  parameter int SUMW = 4 * W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2*W-1:0]    r_in,
  output logic [W-1:0]      a_out,
  output logic [W-1:0]      b_out,
  output logic              busy,
  output logic              done,
  output logic [2*W:0]      err_count,
  output logic [SUMW-1:0]   err_sum,
  output logic [2*W-1:0]    max_err,
  output logic [W-1:0]      max_a,
  output logic [W-1:0]      max_b
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  // {A,B} sweep counter; B is the low half so it is the inner loop.
  logic [2*W-1:0]  cnt_q;
  // Capture stage registers (one pair in flight).
  logic [2*W-1:0]  ed_q;
  logic [W-1:0]    cap_a_q, cap_b_q;
  logic            v_q;
  // Accumulators.
  logic [2*W:0]    err_count_q;
  logic [SUMW-1:0] err_sum_q;
  logic [2*W-1:0]  max_err_q;
  logic [W-1:0]    max_a_q, max_b_q;

  logic            start_ok;
  logic            last_pair;
  logic            capture_en;
  logic [2*W-1:0]  exact;
  logic [2*W-1:0]  ed;

  assign a_out     = cnt_q[2*W-1:W];
  assign b_out     = cnt_q[W-1:0];
  assign last_pair = &cnt_q;

  assign exact = {{W{1'b0}}, a_out} * {{W{1'b0}}, b_out};
  assign ed    = (exact >= r_in) ? (exact - r_in) : (r_in - exact);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last_pair) state_d = S_DRAIN;
      S_DRAIN: state_d = S_DONE;
      S_DONE:  if (start) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / control decode.
  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    start_ok   = 1'b0;
    capture_en = 1'b0;
    case (state_q)
      S_IDLE:  start_ok = start;
      S_RUN:   begin busy = 1'b1; capture_en = 1'b1; end
      S_DRAIN: busy = 1'b1;
      S_DONE:  begin done = 1'b1; start_ok = start; end
      default: ;
    endcase
  end

  // Datapath: capture stage feeds accumulate stage one edge later.
  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      cnt_q       <= '0;
      ed_q        <= '0;
      cap_a_q     <= '0;
      cap_b_q     <= '0;
      v_q         <= 1'b0;
      err_count_q <= '0;
      err_sum_q   <= '0;
      max_err_q   <= '0;
      max_a_q     <= '0;
      max_b_q     <= '0;
    end else begin
      if (v_q) begin
        if (ed_q != '0) err_count_q <= err_count_q + {{(2*W){1'b0}}, 1'b1};
        err_sum_q <= err_sum_q + {{(SUMW-2*W){1'b0}}, ed_q};
        // Strict compare keeps the first pair that reaches the maximum.
        if (ed_q > max_err_q) begin
          max_err_q <= ed_q;
          max_a_q   <= cap_a_q;
          max_b_q   <= cap_b_q;
        end
      end
      if (capture_en) begin
        ed_q    <= ed;
        cap_a_q <= a_out;
        cap_b_q <= b_out;
        v_q     <= 1'b1;
        // Counter holds on the last pair; the FSM moves to DRAIN.
        if (!last_pair) cnt_q <= cnt_q + {{(2*W-1){1'b0}}, 1'b1};
      end else begin
        v_q <= 1'b0;
      end
    end
  end

  assign err_count = err_count_q;
  assign err_sum   = err_sum_q;
  assign max_err   = max_err_q;
  assign max_a     = max_a_q;
  assign max_b     = max_b_q;

endmodule

// File: tb/tb_cdm_error_sweep.sv
// tb/tb_cdm_error_sweep.sv - scoreboard bench for cdm_error_sweep with a table-driven multiplier model
module tb_cdm_error_sweep;
  localparam int W    = 4;
  localparam int SUMW = 4 * W;
  localparam int N    = 1 << (2 * W);

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [2*W-1:0]  r_in;
  logic [W-1:0]    a_out, b_out;
  logic            busy, done;
  logic [2*W:0]    err_count;
  logic [SUMW-1:0] err_sum;
  logic [2*W-1:0]  max_err;
  logic [W-1:0]    max_a, max_b;

  cdm_error_sweep #(.W(W), .SUMW(SUMW)) dut (
    .clk(clk), .rst(rst), .start(start), .r_in(r_in),
    .a_out(a_out), .b_out(b_out), .busy(busy), .done(done),
    .err_count(err_count), .err_sum(err_sum), .max_err(max_err),
    .max_a(max_a), .max_b(max_b)
  );

  always #5 clk = ~clk;

  // Approximate multiplier stand-in: a lookup table indexed by {A,B}.
  logic [2*W-1:0] rtab [N];
  always_comb r_in = rtab[{a_out, b_out}];

  int edge_no = 0;
  always @(posedge clk) edge_no <= edge_no + 1;

  typedef struct {
    int     cnt;
    longint sum;
    int     maxe;
    int     ma;
    int     mb;
    int     done_edge;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Fill the product table for one sweep.
  task automatic fill(input int mode);
    for (int i = 0; i < N; i++) begin
      int a, b, p;
      a = i >> W;
      b = i % (1 << W);
      p = a * b;
      case (mode)
        0: rtab[i] = p[2*W-1:0];
        1: rtab[i] = (a == 3 && b == 5) ? '0 : p[2*W-1:0];
        2: rtab[i] = p[2*W-1:0] & ~(2*W)'(1);
        3: rtab[i] = (p + 2) % N;
        default: rtab[i] = ($urandom_range(0, 7) == 0) ? (2*W)'($urandom_range(0, N - 1))
                                                       : p[2*W-1:0];
      endcase
    end
  endtask

  // Reference: walk all pairs in sweep order with plain arithmetic.
  function automatic exp_t model(input int done_edge);
    exp_t e;
    e.cnt = 0; e.sum = 0; e.maxe = 0; e.ma = 0; e.mb = 0;
    e.done_edge = done_edge;
    for (int a = 0; a < (1 << W); a++)
      for (int b = 0; b < (1 << W); b++) begin
        int r, d;
        r = int'(rtab[a * (1 << W) + b]);
        d = (a * b > r) ? a * b - r : r - a * b;
        if (d != 0) e.cnt++;
        e.sum += d;
        if (d > e.maxe) begin e.maxe = d; e.ma = a; e.mb = b; end
      end
    return e;
  endfunction

  // Monitor: pop and compare whenever results become valid.
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    if (done && !done_prev) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("done_edge", edge_no, e.done_edge);
        chk("err_count", err_count, e.cnt);
        chk("err_sum", err_sum, e.sum);
        chk("max_err", max_err, e.maxe);
        chk("max_a", max_a, e.ma);
        chk("max_b", max_b, e.mb);
        chk("busy_at_done", busy, 0);
      end
    end
    done_prev = done;
  end

  int se;

  task automatic do_start();
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    se = edge_no;
    chk("busy_after_start", busy, 1);
    chk("done_after_start", done, 0);
    chk("a_after_start", a_out, 0);
    chk("b_after_start", b_out, 0);
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!done && k < N + 20) begin
      @(negedge clk);
      k++;
    end
    if (!done) chk("done_timeout", 0, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic sweep(input int mode);
    fill(mode);
    do_start();
    q.push_back(model(se + N + 1));
    wait_done();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_a"}, a_out, 0);
    chk({tag, "_b"}, b_out, 0);
    chk({tag, "_err_count"}, err_count, 0);
    chk({tag, "_err_sum"}, err_sum, 0);
    chk({tag, "_max_err"}, max_err, 0);
    chk({tag, "_max_a"}, max_a, 0);
    chk({tag, "_max_b"}, max_b, 0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    fill(0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_zero("reset");

    sweep(0);
    sweep(1);
    sweep(2);
    sweep(3);
    for (int i = 0; i < 3; i++) sweep(4);

    // Reset mid-sweep discards the partial sweep.
    fill(2);
    do_start();
    repeat (100) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check_zero("midrst");
    sweep(0);

    // Starts while busy are ignored; start in DONE restarts cleanly.
    fill(4);
    do_start();
    q.push_back(model(se + N + 1));
    repeat (9) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (150) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_done();
    chk("done_held", done, 1);
    fill(3);
    do_start();
    q.push_back(model(se + N + 1));
    wait_done();

    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
